// File: rtl/dmem_ctrl.sv
// Shares one single-port, word-wide data memory between the core LSU (port 0) and debug/DMA (port 1).
// Handles RV32I sub-word loads and stores. Define DMEM_CTRL_FIXED_PRIO_EN to give port 0 fixed priority.
module dmem_ctrl #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [1:0]  p0_size,
   input  logic        p0_unsigned,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [1:0]  p1_size,
   input  logic        p1_unsigned,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p0_gnt,
   output logic        p1_gnt,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, MERGE} state_t;

   localparam logic [1:0]  SZ_BYTE    = 2'b00;
   localparam logic [1:0]  SZ_HALF    = 2'b01;
   localparam logic [1:0]  SZ_WORD    = 2'b10;
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

   state_t      state_q, state_d;
   logic        id_q, id_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic        grant;
   logic        sel_id;
   logic        sel_we;
   logic [1:0]  sel_size;
   logic        sel_uns;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_err;

   function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: extract_lane = {{24{b[7] & ~uns}}, b};
         SZ_HALF: extract_lane = {{16{h[15] & ~uns}}, h};
         default: extract_lane = word;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] wdata);
      logic [31:0] m;
      m = word;
      if (size == SZ_BYTE) m[{lane, 3'b000} +: 8] = wdata[7:0];
      else                 m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      return m;
   endfunction

`ifndef DMEM_CTRL_FIXED_PRIO_EN
   logic last_grant_q;

   always_ff @(posedge clk) begin
      if (rst)        last_grant_q <= 1'b1;
      else if (grant) last_grant_q <= sel_id;
   end
`endif

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!rst && state_q == IDLE) begin
         if (p0_req && p1_req) begin
`ifdef DMEM_CTRL_FIXED_PRIO_EN
            p0_gnt = 1'b1;
`else
            p0_gnt = last_grant_q;
            p1_gnt = ~last_grant_q;
`endif
         end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
         end
      end
   end

   assign grant     = p0_gnt | p1_gnt;
   assign sel_id    = p1_gnt;
   assign sel_we    = p1_gnt ? p1_we       : p0_we;
   assign sel_size  = p1_gnt ? p1_size     : p0_size;
   assign sel_uns   = p1_gnt ? p1_unsigned : p0_unsigned;
   assign sel_addr  = p1_gnt ? p1_addr     : p0_addr;
   assign sel_wdata = p1_gnt ? p1_wdata    : p0_wdata;

   assign sel_err = (sel_size == 2'b11)
                 || (sel_size == SZ_HALF && sel_addr[0])
                 || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00)
                 || ({1'b0, sel_addr} >= ADDR_LIMIT);

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = 32'h0;
      rsp_err_d   = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;

      case (state_q)
         IDLE: begin
            if (grant) begin
               id_d    = sel_id;
               we_d    = sel_we;
               size_d  = sel_size;
               uns_d   = sel_uns;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               if (sel_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_id_d    = sel_id;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_addr = {addr_q[31:2], 2'b00};
            if (we_q && size_q == SZ_WORD) begin
               mem_we      = 1'b1;
               mem_wdata   = wdata_q;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               state_d     = IDLE;
            end else begin
               // Sub-word stores read the word here and write it back from MERGE.
               state_d = we_q ? MERGE : CAPTURE;
            end
         end
         CAPTURE: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_rdata_d = extract_lane(mem_rdata, size_q, addr_q[1:0], uns_q);
            state_d     = IDLE;
         end
         MERGE: begin
            mem_we      = 1'b1;
            mem_addr    = {addr_q[31:2], 2'b00};
            mem_wdata   = merge_lane(mem_rdata, size_q, addr_q[1:0], wdata_q);
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) mem_we = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // NOTE: the request latches carry no reset; they are reloaded on every grant before being read.
   always_ff @(posedge clk) begin
      id_q    <= id_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a word memory model on the memory port plus a byte-addressed
// reference memory that predicts every response.
module tb_dmem_ctrl;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        p0_req, p0_we, p0_unsigned, p1_req, p1_we, p1_unsigned;
   logic [1:0]  p0_size, p1_size;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p1_gnt, rsp_valid, rsp_id, rsp_err, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   dmem_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory model: registered read, write-through rdata, plus a backdoor preload port.
   logic [31:0] phys_mem [DEPTH];
   logic        bd_we = 1'b0;
   logic [9:0]  bd_idx = '0;
   logic [31:0] bd_data = '0;
   int          cyc = 0;
   int          wr_count = 0;
   int          last_wr_cyc = -1;
   logic [31:0] last_wr_data = '0;
   logic [31:0] last_wr_addr = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bd_we) begin
         phys_mem[bd_idx] <= bd_data;
      end else if (mem_we) begin
         phys_mem[10'(mem_addr >> 2)] <= mem_wdata;
         mem_rdata    <= mem_wdata;
         wr_count     <= wr_count + 1;
         last_wr_cyc  <= cyc;
         last_wr_data <= mem_wdata;
         last_wr_addr <= mem_addr;
      end else begin
         mem_rdata <= phys_mem[10'(mem_addr >> 2)];
      end
   end

   logic [7:0] ref_mem [DEPTH * 4];
   int n_vec = 0;
   int n_err = 0;

   function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
      return size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
             || addr >= LIMIT;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                            input logic uns);
      int     nb;
      longint v;
      nb = 1 << size;
      v  = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[int'(addr) + i]) << (8 * i));
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
      for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr) + i] = wdata[8 * i +: 8];
   endtask

   task automatic set_req(input int port, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         p0_req = 1'b1; p0_we = we; p0_size = size; p0_unsigned = uns; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = 1'b1; p1_we = we; p1_size = size; p1_unsigned = uns; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic clear_req(input int port);
      if (port == 0) p0_req = 1'b0;
      else           p1_req = 1'b0;
   endtask

   // Drives one request, waits for its grant and its response; lat is response cycle minus grant cycle.
   task automatic run_op(input int port, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic ok, output int a_cyc, output int lat,
                         output logic err, output logic id, output logic [31:0] rdata);
      ok = 1'b0; a_cyc = -1; lat = 0; err = 1'b0; id = 1'b0; rdata = '0;
      @(negedge clk);
      set_req(port, we, size, uns, addr, wdata);
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((port == 0) ? p0_gnt : p1_gnt) begin
            ok = 1'b1;
            a_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         clear_req(port);
         return;
      end
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) clear_req(port);
         if (rsp_valid) begin
            lat = n; err = rsp_err; id = rsp_id; rdata = rsp_rdata;
            break;
         end
      end
   endtask

   task automatic preload();
      logic [31:0] w;
      for (int k = 0; k <= 128; k++) begin
         int idx;
         idx = (k == 128) ? DEPTH - 1 : k;
         w = (idx == 32'h40) ? 32'h8899AABB : $urandom;
         @(negedge clk);
         bd_we = 1'b1; bd_idx = 10'(idx); bd_data = w;
         for (int b = 0; b < 4; b++) ref_mem[idx * 4 + b] = w[8 * b +: 8];
      end
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      set_req(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      #1;
      n_vec++;
      if ({p0_gnt, p1_gnt, mem_we} !== 3'b000) begin
         n_err++; $display("FAIL reset_gnt: gnt0/gnt1/mem_we=%b required 000", {p0_gnt, p1_gnt, mem_we});
      end
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_rdata} !== 35'h0) begin
         n_err++; $display("FAIL reset_rsp: valid=%b id=%b err=%b rdata=%h required all 0",
                           rsp_valid, rsp_id, rsp_err, rsp_rdata);
      end
      clear_req(0); clear_req(1);
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_release: rsp_valid=%b required 0", rsp_valid);
      end
   endtask

   task automatic test_lb();
      logic ok, err, id; int a, lat; logic [31:0] rd;
      run_op(0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, ok, a, lat, err, id, rd);
      n_vec++;
      if ({ok, 4'(lat), err, id, rd} !== {1'b1, 4'd3, 1'b0, 1'b0, 32'hFFFFFFAA}) begin
         n_err++; $display("FAIL lb_signed: ok=%b lat=%0d err=%b id=%b rdata=%h required 1/3/0/0/ffffffaa",
                           ok, lat, err, id, rd);
      end
      run_op(0, 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, ok, a, lat, err, id, rd);
      n_vec++;
      if ({ok, 4'(lat), err, rd} !== {1'b1, 4'd3, 1'b0, 32'h000000AA}) begin
         n_err++; $display("FAIL lbu: ok=%b lat=%0d err=%b rdata=%h required 1/3/0/000000aa", ok, lat, err, rd);
      end
      run_op(0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, ok, a, lat, err, id, rd);
      n_vec++;
      if (rd !== 32'hFFFF8899) begin
         n_err++; $display("FAIL lh_upper: rdata=%h required ffff8899", rd);
      end
   endtask

   task automatic test_sh_rmw();
      logic ok, err, id; int a, lat; logic [31:0] rd;
      run_op(0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, ok, a, lat, err, id, rd);
      ref_store(32'h102, 2'd1, 32'h00001234);
      n_vec++;
      if ({ok, 4'(lat), err, rd} !== {1'b1, 4'd3, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL sh_rsp: ok=%b lat=%0d err=%b rdata=%h required 1/3/0/0", ok, lat, err, rd);
      end
      n_vec++;
      if (last_wr_cyc !== a + 2 || last_wr_data !== 32'h1234AABB || last_wr_addr !== 32'h100) begin
         n_err++; $display("FAIL sh_merge_write: cycle=+%0d data=%h addr=%h required +2/1234aabb/100",
                           last_wr_cyc - a, last_wr_data, last_wr_addr);
      end
      run_op(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, ok, a, lat, err, id, rd);
      n_vec++;
      if (rd !== 32'h1234AABB) begin
         n_err++; $display("FAIL sh_readback: rdata=%h required 1234aabb", rd);
      end
   endtask

   task automatic test_errors();
      logic ok, err, id; int a, lat, wc0; logic [31:0] rd;
      logic [31:0] e_addr [4] = '{32'h102, 32'h1000, 32'h101, 32'h40};
      logic [1:0]  e_size [4] = '{2'd2, 2'd2, 2'd1, 2'd3};
      wc0 = wr_count;
      for (int k = 0; k < 4; k++) begin
         run_op(1, k[0], e_size[k], 1'b0, e_addr[k], 32'hFFFF_FFFF, ok, a, lat, err, id, rd);
         n_vec++;
         if ({ok, 4'(lat), err, id, rd} !== {1'b1, 4'd1, 1'b1, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL err_case%0d: ok=%b lat=%0d err=%b id=%b rdata=%h required 1/1/1/1/0",
                              k, ok, lat, err, id, rd);
         end
      end
      n_vec++;
      if (wr_count !== wc0) begin
         n_err++; $display("FAIL err_no_write: writes=%0d required 0", wr_count - wc0);
      end
      run_op(1, 1'b0, 2'd2, 1'b0, LIMIT - 4, 32'h0, ok, a, lat, err, id, rd);
      n_vec++;
      if ({ok, 4'(lat), err, rd} !== {1'b1, 4'd3, 1'b0, ref_load(LIMIT - 4, 2'd2, 1'b0)}) begin
         n_err++; $display("FAIL last_word: ok=%b lat=%0d err=%b rdata=%h required 1/3/0/%h",
                           ok, lat, err, rd, ref_load(LIMIT - 4, 2'd2, 1'b0));
      end
   endtask

   task automatic test_back_to_back();
      int a; logic got; logic seen;
      got = 1'b0; a = -1; seen = 1'b0;
      @(negedge clk);
      set_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (p0_gnt) begin got = 1'b1; a = cyc; break; end
         @(negedge clk);
      end
      n_vec++;
      if (!got) begin
         n_err++; $display("FAIL b2b_sw_grant: no grant in 20 cycles");
         clear_req(0);
         return;
      end
      ref_store(32'h10, 2'd2, 32'hDEADBEEF);
      @(negedge clk);
      set_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      #1;
      n_vec++;
      if (p0_gnt !== 1'b0) begin
         n_err++; $display("FAIL b2b_issue_gnt: p0_gnt=%b required 0", p0_gnt);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({rsp_valid, rsp_err, p0_gnt} !== 3'b101) begin
         n_err++; $display("FAIL b2b_overlap: rsp_valid/err/p0_gnt=%b required 101 at +%0d",
                           {rsp_valid, rsp_err, p0_gnt}, cyc - a);
      end
      @(negedge clk);
      clear_req(0);
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      n_vec++;
      if (!seen || cyc - a !== 5 || rsp_rdata !== ref_load(32'h10, 2'd2, 1'b0)) begin
         n_err++; $display("FAIL b2b_lw: seen=%b at=+%0d rdata=%h required 1/+5/deadbeef",
                           seen, cyc - a, rsp_rdata);
      end
   endtask

   task automatic test_reset_mid_rmw();
      logic ok, err, id; int a, lat, wc0; logic [31:0] rd; logic got; logic stray;
      got = 1'b0; stray = 1'b0;
      wc0 = wr_count;
      @(negedge clk);
      set_req(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h5A);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (p0_gnt) begin got = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      clear_req(0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (!got || mem_we !== 1'b0) begin
         n_err++; $display("FAIL rst_merge_we: granted=%b mem_we=%b required 1/0", got, mem_we);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) stray = 1'b1;
         @(negedge clk);
      end
      n_vec++;
      if (stray || wr_count !== wc0) begin
         n_err++; $display("FAIL rst_merge_drop: stray_rsp=%b writes=%0d required 0/0", stray, wr_count - wc0);
      end
      set_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      set_req(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
      #1;
      n_vec++;
      if ({p0_gnt, p1_gnt} !== 2'b10) begin
         n_err++; $display("FAIL rst_first_grant: gnt0/gnt1=%b required 10", {p0_gnt, p1_gnt});
      end
      clear_req(0); clear_req(1);
      run_op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, ok, a, lat, err, id, rd);
      n_vec++;
      if (rd !== ref_load(32'h20, 2'd2, 1'b0)) begin
         n_err++; $display("FAIL rst_word_intact: rdata=%h required %h", rd, ref_load(32'h20, 2'd2, 1'b0));
      end
   endtask

   task automatic test_arbitration();
      int ports[$]; int cycs[$]; logic both;
      both = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      set_req(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (p0_gnt && p1_gnt) both = 1'b1;
         if (p0_gnt || p1_gnt) begin
            ports.push_back(p1_gnt ? 1 : 0);
            cycs.push_back(cyc);
            if (ports.size() == 6) break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      clear_req(0); clear_req(1);
      n_vec++;
      if (both || ports.size() != 6) begin
         n_err++; $display("FAIL arb_count: double_grant=%b grants=%0d required 0/6", both, ports.size());
      end
      for (int k = 0; k < ports.size(); k++) begin
         int exp_port;
`ifdef DMEM_CTRL_FIXED_PRIO_EN
         exp_port = 0;
`else
         exp_port = k % 2;
`endif
         n_vec++;
         if (ports[k] !== exp_port || (k > 0 && cycs[k] - cycs[k - 1] !== 3)) begin
            n_err++; $display("FAIL arb_grant%0d: port=%0d spacing=%0d required %0d/3", k, ports[k],
                              (k > 0) ? cycs[k] - cycs[k - 1] : 3, exp_port);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_random();
      logic ok, err, id; int a, lat; logic [31:0] rd;
      for (int t = 0; t < 150; t++) begin
         int port, r, exp_lat; logic we, uns, exp_err; logic [1:0] size; logic [31:0] addr, wdata, exp_rd;
         port  = $urandom_range(0, 1);
         we    = 1'($urandom_range(0, 1));
         uns   = 1'($urandom_range(0, 1));
         wdata = $urandom;
         r     = $urandom_range(0, 15);
         size  = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
         r     = $urandom_range(0, 19);
         if (r == 0)      addr = LIMIT + $urandom_range(0, 255);
         else if (r == 1) addr = LIMIT - 4 + $urandom_range(0, 3);
         else if (r == 2) addr = 32'h8000_0000 | $urandom;
         else             addr = $urandom_range(0, 511);
         exp_err = ref_err(addr, size);
         exp_rd  = '0;
         if (exp_err)      exp_lat = 1;
         else if (we)      exp_lat = (size == 2'd2) ? 2 : 3;
         else              exp_lat = 3;
         if (!exp_err && !we) exp_rd = ref_load(addr, size, uns);
         run_op(port, we, size, uns, addr, wdata, ok, a, lat, err, id, rd);
         if (!exp_err && we) ref_store(addr, size, wdata);
         n_vec++;
         if ({ok, 4'(lat), err, id, rd} !== {1'b1, 4'(exp_lat), exp_err, 1'(port), exp_rd}) begin
            n_err++; $display("FAIL rand%0d p%0d we=%b sz=%0d u=%b a=%h: ok=%b lat=%0d err=%b id=%b rdata=%h required 1/%0d/%b/%0d/%h",
                              t, port, we, size, uns, addr, ok, lat, err, id, rd, exp_lat, exp_err, port, exp_rd);
         end
      end
   endtask

   initial begin
      p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'd0; p0_unsigned = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'd0; p1_unsigned = 1'b0; p1_addr = '0; p1_wdata = '0;
      rst = 1'b1;
      preload();
      test_reset();
      test_lb();
      test_sh_rmw();
      test_errors();
      test_back_to_back();
      test_reset_mid_rmw();
      test_arbitration();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Sequences and shares the single-port, word-only data memory between two requesters: port 0 (core LSU, MEM stage) and port 1 (debug/DMA).
- Provides RV32I sub-word access. Loads LB/LBU/LH/LHU/LW get lane extraction and sign/zero extension.
- Stores SB/SH are done as read-modify-write. SW is a direct write.
- Sits between the pipeline MEM stage and the memory. The memory registers its read data (1-cycle latency), and on a write its rdata returns the written word.

Parameters:
- DEPTH, 1024, memory depth in 32-bit words. Legal byte addresses are 0 to DEPTH*4-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- p0_req, p1_req  in  1  request valid; held with its fields until granted
- p0_we, p1_we  in  1  1 = store, 0 = load
- p0_size, p1_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- p0_unsigned, p1_unsigned  in  1  load zero-extend (LBU/LHU)
- p0_addr, p1_addr  in  32  byte address
- p0_wdata, p1_wdata  in  32  store data, right-aligned
- p0_gnt, p1_gnt  out  1  combinational; request accepted this cycle
- rsp_valid  out  1  registered one-cycle completion pulse
- rsp_id  out  1  port the response belongs to
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range, or size 11
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address (word-aligned)
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after a read is issued

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0; last_grant=1.
  - mem_we is forced 0 whenever rst=1, including mid-RMW. In-flight requests are dropped with no response. gnt=0 while rst=1.
- States: IDLE, ISSUE, CAPTURE, MERGE.
- Grant rules:
  - Grants occur only in IDLE.
  - One requester: it is granted.
  - Both requesting: round-robin, the port not in last_grant wins; last_grant updates on every grant.
  - On grant the controller latches id, we, size, unsigned, addr and wdata.
- Error check at grant:
  - Errors: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= DEPTH*4.
  - On error: no memory access, stay IDLE, rsp_valid=1 with rsp_err=1 and rsp_rdata=0 next cycle (grant cycle A, response A+1).
- Normal flow (grant in cycle A):
  - ISSUE (A+1): mem_addr = {latched addr[31:2], 2'b00}.
  - Word store: mem_we=1, mem_wdata=wdata; next state IDLE; response at A+2.
  - Load: mem_we=0; next state CAPTURE.
  - Sub-word store: mem_we=0 (read); next state MERGE.
- CAPTURE (A+2):
  - Extract lane from mem_rdata. Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend unless unsigned; word passes through.
  - Register into rsp_rdata; rsp_valid at A+3; go IDLE.
- MERGE (A+2):
  - mem_we=1; mem_wdata = mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0].
  - Response at A+3; go IDLE.
- Outside ISSUE/MERGE: mem_we=0, mem_addr=0, mem_wdata=0.
- The response cycle coincides with IDLE, so a new grant may occur in the same cycle as rsp_valid.
- Throughput per port: LW/LB 3 cycles, SW 2, SB/SH 3.

Optional Feature:
- Macro DMEM_CTRL_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests; last_grant is unused (port 1 can starve).
- Undefined: round-robin as above.

Test Plan:
- Preload word 0x100=0x8899AABB; p0 LB addr 0x101 -> grant at A, rsp_valid at A+3, rsp_rdata=0xFFFFFFAA, rsp_id=0, rsp_err=0. Same with unsigned=1 -> 0x000000AA.
- p0 SH addr 0x102 wdata 0x00001234 on word 0x8899AABB -> mem_we=1 at A+2 with mem_wdata=0x1234AABB; following LW 0x100 returns 0x1234AABB.
- p0 and p1 both request LW every cycle -> grants alternate p0,p1,p0,... starting with p0 after reset. With DMEM_CTRL_FIXED_PRIO_EN, p1_gnt stays 0.
- p1 LW addr 0x102 -> rsp_err=1 at A+1, rsp_rdata=0, mem_we never 1. LW addr 0x1000 with DEPTH=1024 -> same response.
- SB in progress, rst=1 during MERGE cycle -> mem_we=0 that cycle, memory word unchanged, no rsp_valid, next grant goes to p0.
- Back-to-back p0 SW 0x10=0xDEADBEEF then LW 0x10 -> SW rsp at A+2 with second grant that cycle; LW returns 0xDEADBEEF.
